// File: rtl/wave_capture_pkg.sv
// Shared definitions for the wave capture writer: FSM state encoding,
// default geometry of the double-buffered 512x8 wave RAM, and the
// auto-trigger timeout length used when WAVE_CAPTURE_AUTOTRIG_EN is defined.
package wave_capture_pkg;

    localparam int DEF_SAMPLE_W    = 16;
    localparam int DEF_NUM_SAMPLES = 256;
    localparam int DEF_ADDR_LO_W   = 8;
    localparam int TIMEOUT_SAMPLES = 1024;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

endpackage

// File: rtl/wave_capture_if.sv
// Bus between the wave capture writer and its surroundings: the codec
// sample stream, the display handshake and the wave RAM write port.
// The address is {half select, sample index}; the display uses read_index
// as the MSB of its own read address.
interface wave_capture_if
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int ADDR_LO_W = DEF_ADDR_LO_W
);
    logic                 new_sample_ready;
    logic [SAMPLE_W-1:0]  new_sample_in;
    logic                 wave_display_idle;
    logic [ADDR_LO_W:0]   write_address;
    logic                 write_enable;
    logic [7:0]           write_sample;
    logic                 read_index;

    // Capture block side
    modport master (
        input  new_sample_ready,
        input  new_sample_in,
        input  wave_display_idle,
        output write_address,
        output write_enable,
        output write_sample,
        output read_index
    );

    // Codec / display / RAM side
    modport slave (
        output new_sample_ready,
        output new_sample_in,
        output wave_display_idle,
        input  write_address,
        input  write_enable,
        input  write_sample,
        input  read_index
    );
endinterface

// File: rtl/wave_capture_trigger.sv
// Trigger detector for the wave capture writer. Remembers the sign of the
// previous sample and flags a positive-going zero crossing on the current
// strobe. With WAVE_CAPTURE_AUTOTRIG_EN defined, a timeout counter forces a
// trigger after TIMEOUT_SAMPLES strobes in ARMED so DC or silence still
// refreshes the display. The trigger is a combinational one-cycle pulse
// qualified by the strobe and by the ARMED state.
module wave_capture_trigger
    import wave_capture_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic sample_ready,
    input  logic sample_sign,
    input  logic armed,
    output logic trigger
);
    logic prev_sign_reg;
    logic crossing;

    // Only the sign of the previous sample matters for the crossing test
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_sign_reg <= 1'b0;
        end else if (sample_ready) begin
            prev_sign_reg <= sample_sign;
        end
    end

    assign crossing = sample_ready & prev_sign_reg & ~sample_sign;

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES) + 1;

    logic [TO_W-1:0] timeout_reg;
    logic            timeout_hit;

    assign timeout_hit = (timeout_reg == TO_W'(TIMEOUT_SAMPLES - 1));

    // Count strobes while armed; held at zero elsewhere so it restarts on entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_reg <= '0;
        end else if (!armed) begin
            timeout_reg <= '0;
        end else if (sample_ready && !timeout_hit) begin
            timeout_reg <= timeout_reg + 1'b1;
        end
    end

    assign trigger = armed & (crossing | (sample_ready & timeout_hit));
`else
    assign trigger = armed & crossing;
`endif

endmodule

// File: rtl/wave_capture.sv
// Writer side of the double-buffered wave RAM. Waits for a trigger, writes
// NUM_SAMPLES converted samples into the half the display is not reading,
// then waits for the display to go idle and flips read_index.
// Optional feature: define WAVE_CAPTURE_AUTOTRIG_EN for a forced trigger
// after a timeout in ARMED.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int NUM_SAMPLES = DEF_NUM_SAMPLES,
    parameter int ADDR_LO_W   = DEF_ADDR_LO_W
)(
    input  logic           clk,
    input  logic           reset_n,
    wave_capture_if.master bus
);
    state_t                 state_reg,      state_next;
    logic [ADDR_LO_W-1:0]   count_reg,      count_next;
    logic                   read_index_reg, read_index_next;
    logic                   we_reg,         we_next;
    logic [ADDR_LO_W:0]     addr_reg,       addr_next;
    logic [7:0]             sample_reg,     sample_next;
    logic                   trigger;
    logic [7:0]             sample_conv;

    wave_capture_trigger u_trigger (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_ready (bus.new_sample_ready),
        .sample_sign  (bus.new_sample_in[SAMPLE_W-1]),
        .armed        (state_reg == ST_ARMED),
        .trigger      (trigger)
    );

    // Signed sample to offset binary: flip the sign, keep the next 7 MSBs
    assign sample_conv = {~bus.new_sample_in[SAMPLE_W-1],
                          bus.new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};

    // Next-state and registered write-port decisions
    always_comb begin
        state_next      = state_reg;
        count_next      = count_reg;
        read_index_next = read_index_reg;
        we_next         = 1'b0;
        addr_next       = addr_reg;
        sample_next     = sample_reg;
        case (state_reg)
            ST_ARMED: begin
                if (trigger) begin
                    we_next     = 1'b1;
                    addr_next   = {~read_index_reg, {ADDR_LO_W{1'b0}}};
                    sample_next = sample_conv;
                    count_next  = ADDR_LO_W'(1);
                    state_next  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (bus.new_sample_ready) begin
                    we_next     = 1'b1;
                    addr_next   = {~read_index_reg, count_reg};
                    sample_next = sample_conv;
                    if (count_reg == ADDR_LO_W'(NUM_SAMPLES - 1)) begin
                        count_next = '0;
                        state_next = ST_WAIT;
                    end else begin
                        count_next = count_reg + 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                // Strobes are ignored here; the flip waits for a safe display moment
                if (bus.wave_display_idle) begin
                    read_index_next = ~read_index_reg;
                    state_next      = ST_ARMED;
                end
            end
            default: begin
                state_next = ST_ARMED;
            end
        endcase
    end

    // State, counter, page select and write-port registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_ARMED;
            count_reg      <= '0;
            read_index_reg <= 1'b0;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            sample_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            count_reg      <= count_next;
            read_index_reg <= read_index_next;
            we_reg         <= we_next;
            addr_reg       <= addr_next;
            sample_reg     <= sample_next;
        end
    end

    assign bus.write_enable  = we_reg;
    assign bus.write_address = addr_reg;
    assign bus.write_sample  = sample_reg;
    assign bus.read_index    = read_index_reg;

endmodule

// File: tb/tb_wave_capture.sv
// Directed testbench for wave_capture: trigger, full capture into each half,
// WAIT/flip handling, simultaneous strobe+idle, async reset mid-capture and
// the optional auto-trigger timeout (WAVE_CAPTURE_AUTOTRIG_EN).
module tb_wave_capture;

    logic clk;
    logic reset_n;
    int   total_checks;
    int   passed_checks;
    int   writes_seen;

    wave_capture_if wif ();

    wave_capture dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (wif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] S_ARMED  = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        assert (got === exp) begin
            passed_checks++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One-cycle strobe; returns 1 ns after the capturing edge so the
    // registered write caused by this strobe is visible.
    task automatic strobe(input logic [15:0] v, input logic idle);
        @(posedge clk); #1;
        wif.new_sample_ready  = 1'b1;
        wif.new_sample_in     = v;
        wif.wave_display_idle = idle;
        @(posedge clk); #1;
        wif.new_sample_ready  = 1'b0;
        wif.wave_display_idle = 1'b0;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        writes_seen   = 0;
        reset_n = 1'b0;
        wif.new_sample_ready  = 1'b0;
        wif.new_sample_in     = '0;
        wif.wave_display_idle = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_we",    32'(wif.write_enable),  32'h0);
        check("reset_addr",  32'(wif.write_address), 32'h0);
        check("reset_samp",  32'(wif.write_sample),  32'h0);
        check("reset_ridx",  32'(wif.read_index),    32'h0);
        check("reset_state", 32'(dut.state_reg),     32'(S_ARMED));
        reset_n = 1'b1;

        // Positive samples only: no crossing
        strobe(16'd3, 1'b0);
        check("notrig1_we", 32'(wif.write_enable), 32'h0);
        strobe(16'd7, 1'b0);
        check("notrig2_we", 32'(wif.write_enable), 32'h0);
        check("notrig_state", 32'(dut.state_reg), 32'(S_ARMED));

        // -5 then +3: trigger, first write to 0x100 with 0x80
        strobe(-16'sd5, 1'b0);
        check("neg_we", 32'(wif.write_enable), 32'h0);
        strobe(16'd3, 1'b0);
        check("trig_we",    32'(wif.write_enable),  32'h1);
        check("trig_addr",  32'(wif.write_address), 32'h100);
        check("trig_samp",  32'(wif.write_sample),  32'h80);
        check("trig_state", 32'(dut.state_reg),     32'(S_ACTIVE));
        @(posedge clk); #1;
        check("we_single_cycle", 32'(wif.write_enable), 32'h0);

        // Remaining 255 writes: value i<<8 converts to i^0x80
        for (int i = 1; i < 256; i++) begin
            strobe(16'(i * 256), 1'b0);
            check("burst0_we",   32'(wif.write_enable),  32'h1);
            check("burst0_addr", 32'(wif.write_address), 32'(9'h100 + i));
            check("burst0_samp", 32'(wif.write_sample),  32'(8'(i) ^ 8'h80));
        end
        check("burst0_wait", 32'(dut.state_reg), 32'(S_WAIT));

        // Strobe 257 is ignored in WAIT
        strobe(16'd1, 1'b0);
        check("wait_no_we",  32'(wif.write_enable), 32'h0);
        check("wait_state",  32'(dut.state_reg),    32'(S_WAIT));
        check("wait_ridx",   32'(wif.read_index),   32'h0);

        // Idle pulse flips read_index
        @(posedge clk); #1;
        wif.wave_display_idle = 1'b1;
        @(posedge clk); #1;
        wif.wave_display_idle = 1'b0;
        check("flip_ridx",  32'(wif.read_index), 32'h1);
        check("flip_state", 32'(dut.state_reg),  32'(S_ARMED));

        // Second capture goes to half 0
        strobe(16'hFFFF, 1'b0);
        strobe(16'h1234, 1'b0);
        check("cap1_we",   32'(wif.write_enable),  32'h1);
        check("cap1_addr", 32'(wif.write_address), 32'h000);
        check("cap1_samp", 32'(wif.write_sample),  32'h92);
        for (int i = 1; i < 256; i++) begin
            strobe(16'h0000, 1'b0);
            check("burst1_addr", 32'(wif.write_address), 32'(i));
            check("burst1_samp", 32'(wif.write_sample),  32'h80);
        end
        check("burst1_wait", 32'(dut.state_reg), 32'(S_WAIT));

        // Strobe + idle together in WAIT, with a would-be crossing
        strobe(-16'sd7, 1'b0);
        check("wait2_no_we", 32'(wif.write_enable), 32'h0);
        strobe(16'd5, 1'b1);
        check("simul_no_we", 32'(wif.write_enable), 32'h0);
        check("simul_ridx",  32'(wif.read_index),   32'h0);
        check("simul_state", 32'(dut.state_reg),    32'(S_ARMED));
        @(posedge clk); #1;
        check("simul_no_trig", 32'(dut.state_reg), 32'(S_ARMED));
        strobe(16'd5, 1'b0);
        check("simul_after_we", 32'(wif.write_enable), 32'h0);

        // Reset in the middle of a capture
        strobe(16'hFFFF, 1'b0);
        strobe(16'h7F00, 1'b0);
        check("cap2_addr", 32'(wif.write_address), 32'h100);
        check("cap2_samp", 32'(wif.write_sample),  32'hFF);
        repeat (10) strobe(16'h4000, 1'b0);
        check("cap2_mid_addr", 32'(wif.write_address), 32'h10A);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_we",    32'(wif.write_enable),  32'h0);
        check("async_addr",  32'(wif.write_address), 32'h0);
        check("async_samp",  32'(wif.write_sample),  32'h0);
        check("async_ridx",  32'(wif.read_index),    32'h0);
        check("async_state", 32'(dut.state_reg),     32'(S_ARMED));
        @(posedge clk); #1;
        reset_n = 1'b1;
        strobe(16'hFFFF, 1'b0);
        strobe(16'h0001, 1'b0);
        check("post_rst_we",   32'(wif.write_enable),  32'h1);
        check("post_rst_addr", 32'(wif.write_address), 32'h100);

        // Constant +100 from reset: auto-trigger only when enabled
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        writes_seen = 0;
        for (int i = 0; i < 1023; i++) begin
            strobe(16'd100, 1'b0);
            if (wif.write_enable) writes_seen++;
        end
        check("timeout_pre_writes", 32'(writes_seen), 32'h0);
        strobe(16'd100, 1'b0);
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
        check("timeout_we",   32'(wif.write_enable),  32'h1);
        check("timeout_addr", 32'(wif.write_address), 32'h100);
        check("timeout_samp", 32'(wif.write_sample),  32'h80);
`else
        check("no_timeout_we", 32'(wif.write_enable), 32'h0);
        for (int i = 0; i < 100; i++) begin
            strobe(16'd100, 1'b0);
            if (wif.write_enable) writes_seen++;
        end
        check("no_timeout_writes", 32'(writes_seen), 32'h0);
        check("no_timeout_state",  32'(dut.state_reg), 32'(S_ARMED));
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
